// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned,
// with a start/busy/done handshake toward the pipeline stall logic.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_dvsr_zero;
    logic             w_dvd_neg;
    logic             w_dvsr_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvsr_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_last;

    assign w_accept    = start_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_dvsr_zero = (divisor_i == '0);
    assign w_dvd_neg   = signed_i & dividend_i[WIDTH-1];
    assign w_dvsr_neg  = signed_i & divisor_i[WIDTH-1];
    // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign w_dvd_abs   = w_dvd_neg  ? (~dividend_i + 1'b1) : dividend_i;
    assign w_dvsr_abs  = w_dvsr_neg ? (~divisor_i + 1'b1)  : divisor_i;

    // rem < divisor always holds, so WIDTH+1 bits capture the shifted value and the borrow.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) w_next = w_dvsr_zero ? S_DONE : S_CALC;
                else         w_next = S_IDLE;
            end
            S_CALC: w_next = w_last ? S_FIX : S_CALC;
            S_FIX:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_CALC, S_FIX: busy_o = 1'b1;
            S_DONE:        done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_rem      <= '0;
            r_quo      <= w_dvd_abs;
            r_dvsr     <= w_dvsr_abs;
            r_cnt      <= '0;
            r_neg_q    <= w_dvd_neg ^ w_dvsr_neg;
            r_neg_r    <= w_dvd_neg;
            r_div_zero <= w_dvsr_zero;
            // Divide-by-zero skips the iterations and reports the raw dividend.
            if (w_dvsr_zero) begin
                r_quotient  <= '1;
                r_remainder <= dividend_i;
            end
        end else if (r_state == S_CALC) begin
            r_rem <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
            r_cnt <= r_cnt + CW'(1);
        end else if (r_state == S_FIX) begin
            r_quotient  <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
            r_remainder <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
        end
    end

    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;
    assign div_zero_o  = r_div_zero;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: latency, signed/unsigned results, divide-by-zero,
// ignored starts, back-to-back operation and asynchronous reset abort.
module tb_iter_divider;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic         signed_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_zero_o;

    int checks = 0;
    int passed = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o),
        .done_o(done_o), .quotient_o(quotient_o), .remainder_o(remainder_o),
        .div_zero_o(div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Caller sits at a negedge; returns at the negedge of the first cycle after the accept edge.
    task automatic launch(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        signed_i = sg; dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Counts cycles after the accept edge until done_o is seen; leaves us at the DONE-cycle negedge.
    task automatic wait_done(output int lat, output int busyc);
        lat = 1; busyc = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) busyc++;
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy_o, done_o, quotient_o, remainder_o, div_zero_o} !== '0)
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, need all 0",
                     busy_o, done_o, quotient_o, remainder_o, div_zero_o);
        else passed++;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_unsigned_latency();
        int lat, busyc;
        launch(1'b0, 32'd100, 32'd7);
        wait_done(lat, busyc);
        checks++;
        if (lat !== 34) $display("FAIL u_latency: got %0d, need 34", lat); else passed++;
        checks++;
        if (busyc !== 33) $display("FAIL u_busy_cycles: got %0d, need 33", busyc); else passed++;
        checks++;
        if ({quotient_o, remainder_o, div_zero_o} !== {32'd14, 32'd2, 1'b0})
            $display("FAIL u_100_7: got q=%0d r=%0d dz=%b, need q=14 r=2 dz=0",
                     quotient_o, remainder_o, div_zero_o);
        else passed++;
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL done_one_cycle: got done=%b busy=%b, need 0 0", done_o, busy_o);
        else passed++;
        checks++;
        if (quotient_o !== 32'd14) $display("FAIL q_held: got %0d, need 14", quotient_o);
        else passed++;
    endtask

    task automatic test_signed();
        int lat, busyc;
        logic [W-1:0] va [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'd7};
        logic [W-1:0] vb [5] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE};
        logic         vs [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] eq [5] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000, 32'hC0000000, 32'hFFFFFFFD};
        logic [W-1:0] er [5] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            launch(vs[i], va[i], vb[i]);
            wait_done(lat, busyc);
            checks++;
            if (lat !== 34 || quotient_o !== eq[i] || remainder_o !== er[i])
                $display("FAIL signed_vec%0d: got lat=%0d q=%h r=%h, need lat=34 q=%h r=%h",
                         i, lat, quotient_o, remainder_o, eq[i], er[i]);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        int lat, busyc;
        @(negedge clk_i);
        launch(1'b1, 32'h12345678, 32'd0);
        wait_done(lat, busyc);
        checks++;
        if (lat !== 1 || busyc !== 0)
            $display("FAIL dz_timing: got lat=%0d busy=%0d, need lat=1 busy=0", lat, busyc);
        else passed++;
        checks++;
        if ({quotient_o, remainder_o, div_zero_o} !== {32'hFFFFFFFF, 32'h12345678, 1'b1})
            $display("FAIL dz_result: got q=%h r=%h dz=%b, need q=ffffffff r=12345678 dz=1",
                     quotient_o, remainder_o, div_zero_o);
        else passed++;
        @(negedge clk_i);
        launch(1'b0, 32'd6, 32'd3);
        wait_done(lat, busyc);
        checks++;
        if ({quotient_o, remainder_o, div_zero_o} !== {32'd2, 32'd0, 1'b0} || lat !== 34)
            $display("FAIL dz_clear: got lat=%0d q=%0d r=%0d dz=%b, need lat=34 q=2 r=0 dz=0",
                     lat, quotient_o, remainder_o, div_zero_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, busyc;
        @(negedge clk_i);
        launch(1'b0, 32'd50, 32'd5);
        // Stray start plus operand changes mid-flight must not disturb the operation.
        repeat (9) @(negedge clk_i);
        start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd0;
        lat = 11; busyc = 0;
        while (!done_o && lat < 100) begin
            @(negedge clk_i);
            lat++;
        end
        checks++;
        if (lat !== 34 || quotient_o !== 32'd10 || remainder_o !== 32'd0)
            $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d, need lat=34 q=10 r=0",
                     lat, quotient_o, remainder_o);
        else passed++;
        launch(1'b0, 32'd9, 32'd3);
        wait_done(lat, busyc);
        checks++;
        if (lat !== 34 || quotient_o !== 32'd3 || remainder_o !== 32'd0)
            $display("FAIL back_to_back: got lat=%0d q=%0d r=%0d, need lat=34 q=3 r=0",
                     lat, quotient_o, remainder_o);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int lat, busyc, dones;
        @(negedge clk_i);
        launch(1'b0, 32'd1000, 32'd10);
        repeat (14) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, quotient_o, remainder_o, div_zero_o} !== '0)
            $display("FAIL async_reset: got busy=%b done=%b q=%h r=%h dz=%b, need all 0",
                     busy_o, done_o, quotient_o, remainder_o, div_zero_o);
        else passed++;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o || busy_o) dones++;
        end
        checks++;
        if (dones !== 0) $display("FAIL abort_no_done: got %0d active cycles, need 0", dones);
        else passed++;
        launch(1'b0, 32'd1000, 32'd10);
        wait_done(lat, busyc);
        checks++;
        if (lat !== 34 || quotient_o !== 32'd100 || remainder_o !== 32'd0)
            $display("FAIL after_reset: got lat=%0d q=%0d r=%0d, need lat=34 q=100 r=0",
                     lat, quotient_o, remainder_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
